// File: rtl/phase_select_seq.sv
// Glitch-managed phase selector.
// One of NUM_PHASES phase inputs is routed to phase_out through an enable gate.
// A select change closes the gate while the old phase is low, waits, moves the
// select, waits again, and reopens the gate while the new phase is low, so
// phase_out never carries a truncated pulse from either phase.
module phase_select_seq #(
    parameter int NUM_PHASES    = 8,
    parameter int SEL_W         = $clog2(NUM_PHASES),
    parameter int RESET_SEL     = 0,
    parameter int SETTLE_CYCLES = 4,
    parameter int GATE_TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_PHASES-1:0] phases,
    input  logic                  req_valid,
    input  logic [SEL_W-1:0]      req_sel,
    output logic                  req_ready,
    output logic                  phase_out,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy,
    output logic                  switch_done,
    output logic                  err_range,
    output logic                  timeout_flag
);

    // Phase vector padded to a power of two so any select value indexes safely
    localparam int PAD_W = 1 << SEL_W;
    // Settle counter holds SETTLE_CYCLES-1 down to 0
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // Timeout counter holds 0 up to GATE_TIMEOUT-1
    localparam int TMO_W = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(GATE_TIMEOUT - 1);
    localparam logic [SEL_W-1:0] RESET_SEL_V  = SEL_W'(RESET_SEL);
    localparam logic [SEL_W:0]   NUM_PHASES_V = (SEL_W + 1)'(NUM_PHASES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE_OFF,
        ST_SETTLE_A,
        ST_SWITCH,
        ST_SETTLE_B,
        ST_GATE_ON
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic             gate_en_q, gate_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             samp_q, samp_d;
    logic             tgt_samp_q, tgt_samp_d;
    logic             switch_done_q, switch_done_d;
    logic             err_range_q, err_range_d;
    logic             timeout_flag_q, timeout_flag_d;

    logic [PAD_W-1:0] phases_pad;
    logic             req_fire;
    logic             req_oob;
    logic             req_same;
    logic             off_force;
    logic             on_force;

    // Zero-extend the phase inputs to the full select range
    always_comb begin
        phases_pad                 = '0;
        phases_pad[NUM_PHASES-1:0] = phases;
    end

    // Request classification and forced-transition conditions
    always_comb begin
        req_fire  = req_valid && (state_q == ST_IDLE);
        req_oob   = ({1'b0, req_sel} >= NUM_PHASES_V);
        req_same  = (req_sel == cur_sel_q);
        off_force = samp_q && (tmo_q == TMO_LAST);
        on_force  = tgt_samp_q && (tmo_q == TMO_LAST);
    end

    // Single-register samples of the current and the target phase
    always_comb begin
        samp_d     = phases_pad[cur_sel_q];
        tgt_samp_d = phases_pad[target_q];
    end

    // Switch sequencer: next state plus all datapath register updates
    always_comb begin
        state_d        = state_q;
        cur_sel_d      = cur_sel_q;
        target_d       = target_q;
        gate_en_d      = gate_en_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        switch_done_d  = 1'b0;
        err_range_d    = 1'b0;
        timeout_flag_d = timeout_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    if (req_oob) begin
                        err_range_d = 1'b1;
                    end else if (req_same) begin
                        switch_done_d = 1'b1;
                    end else begin
                        target_d = req_sel;
                        tmo_d    = '0;
                        state_d  = ST_GATE_OFF;
                    end
                end
            end

            ST_GATE_OFF: begin
                if (!samp_q || off_force) begin
                    gate_en_d = 1'b0;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_SETTLE_A;
                    if (off_force) begin
                        timeout_flag_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_SETTLE_A: begin
                if (cnt_q == '0) begin
                    state_d = ST_SWITCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_SWITCH: begin
                cur_sel_d = target_q;
                cnt_d     = CNT_LOAD;
                state_d   = ST_SETTLE_B;
            end

            ST_SETTLE_B: begin
                if (cnt_q == '0) begin
                    tmo_d   = '0;
                    state_d = ST_GATE_ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_GATE_ON: begin
                if (!tgt_samp_q || on_force) begin
                    gate_en_d     = 1'b1;
                    switch_done_d = 1'b1;
                    state_d       = ST_IDLE;
                    if (on_force) begin
                        timeout_flag_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Select, gate, counters and phase samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel_q  <= RESET_SEL_V;
            target_q   <= RESET_SEL_V;
            gate_en_q  <= 1'b1;
            cnt_q      <= '0;
            tmo_q      <= '0;
            samp_q     <= 1'b0;
            tgt_samp_q <= 1'b0;
        end else begin
            cur_sel_q  <= cur_sel_d;
            target_q   <= target_d;
            gate_en_q  <= gate_en_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            samp_q     <= samp_d;
            tgt_samp_q <= tgt_samp_d;
        end
    end

    // Status pulses and the sticky timeout indicator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_done_q  <= 1'b0;
            err_range_q    <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            switch_done_q  <= switch_done_d;
            err_range_q    <= err_range_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign phase_out    = phases_pad[cur_sel_q] & gate_en_q;
    assign cur_sel      = cur_sel_q;
    assign switch_done  = switch_done_q;
    assign err_range    = err_range_q;
    assign timeout_flag = timeout_flag_q;

    // A completion and a range error can never be reported in the same cycle
    a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(switch_done_q && err_range_q));

    // The select may only move while the output gate is closed
    a_sel_gated: assert property (@(posedge clk) disable iff (!rst_n)
        (cur_sel_q != $past(cur_sel_q)) |-> !gate_en_q);

endmodule

// File: tb/tb_phase_select_seq.sv
// Testbench for phase_select_seq (six phases so out-of-range selects exist).
module tb_phase_select_seq;

    localparam int NP = 6;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic [NP-1:0] phases;
    logic [NP-1:0] static_phases;
    logic [NP-1:0] fr_phases = '0;
    bit            free_run;
    logic          req_valid;
    logic [SW-1:0] req_sel;
    logic          req_ready;
    logic          phase_out;
    logic [SW-1:0] cur_sel;
    logic          busy;
    logic          switch_done;
    logic          err_range;
    logic          timeout_flag;

    typedef struct {
        bit    is_err;
        int    sel;
        int    cyc;
        string name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int total = 0;
    int passed = 0;
    int cycle = 0;
    int hs;

    bit glitch_en;
    int run;
    bit armed;
    int runs_seen = 0;
    logic [SW-1:0] prev_sel;

    assign phases = free_run ? fr_phases : static_phases;

    phase_select_seq #(
        .NUM_PHASES   (NP),
        .RESET_SEL    (0),
        .SETTLE_CYCLES(4),
        .GATE_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phases      (phases),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .phase_out   (phase_out),
        .cur_sel     (cur_sel),
        .busy        (busy),
        .switch_done (switch_done),
        .err_range   (err_range),
        .timeout_flag(timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    // Free-running phases: period 8 cycles, 4 high, phase i delayed by i cycles
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NP; i++) begin
            fr_phases[i] = (((cycle + 8 - i) % 8) < 4);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual == expected) begin
            passed = passed + 1;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Issue one request; lat counts clock edges from the handshake edge
    // (inclusive) to the edge that raises the response, 0 = no response
    task automatic applyStimulus(input int sel, input int lat, input bit is_err,
                                 input int exp_sel, input string name, output int h);
        exp_t e;
        @(negedge clk);
        checkOutput({name, " req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_sel   = sel[SW-1:0];
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        h = cycle;
        if (lat > 0) begin
            e.is_err = is_err;
            e.sel    = exp_sel;
            e.cyc    = h + lat - 1;
            e.name   = name;
            exp_q.push_back(e);
        end
    endtask

    task automatic waitDrain(input int max_cyc, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput({name, " response seen"}, exp_q.size(), 0);
    endtask

    // Response monitor, select-change gate check and pulse-width tracker
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sel = cur_sel;
            run      = 0;
            armed    = 1'b0;
        end else begin
            if (cur_sel != prev_sel) begin
                checkOutput("gate closed at select change", dut.gate_en_q, 0);
            end
            prev_sel = cur_sel;

            if (switch_done || err_range) begin
                checkOutput("done/err exclusive", switch_done & err_range, 0);
                if (exp_q.size() == 0) begin
                    total = total + 1;
                    $display("[TB] FAIL unexpected pulse: switch_done=%0b err_range=%0b at cycle %0d, expected none",
                             switch_done, err_range, cycle);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput({mon_e.name, " kind"}, err_range, mon_e.is_err);
                    checkOutput({mon_e.name, " cur_sel"}, cur_sel, mon_e.sel);
                    checkOutput({mon_e.name, " cycle"}, cycle, mon_e.cyc);
                end
            end

            if (!glitch_en) begin
                run   = 0;
                armed = 1'b0;
            end else if (!phase_out) begin
                if (armed && run > 0) begin
                    checkOutput("phase_out pulse >= 4", (run >= 4) ? 1 : 0, 1);
                    runs_seen = runs_seen + 1;
                end
                run   = 0;
                armed = 1'b1;
            end else if (armed) begin
                run = run + 1;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_sel       = '0;
        static_phases = 6'h01;
        free_run      = 1'b0;
        glitch_en     = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        checkOutput("rst phase_out", phase_out, 1);
        checkOutput("rst cur_sel", cur_sel, 0);
        checkOutput("rst req_ready", req_ready, 1);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst switch_done", switch_done, 0);
        checkOutput("rst err_range", err_range, 0);
        checkOutput("rst timeout_flag", timeout_flag, 0);
        checkOutput("rst gate_en", dut.gate_en_q, 1);

        // Minimum-latency switch 0 -> 3 with all phases low
        static_phases = '0;
        applyStimulus(3, 12, 1'b0, 3, "sw0to3", hs);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("sw0to3 busy", busy, 1);
            checkOutput("sw0to3 req_ready", req_ready, 0);
            checkOutput("sw0to3 phase_out", phase_out, 0);
        end
        waitDrain(40, "sw0to3");
        checkOutput("sw0to3 final cur_sel", cur_sel, 3);
        checkOutput("sw0to3 final gate_en", dut.gate_en_q, 1);
        checkOutput("sw0to3 final busy", busy, 0);

        // Same select: immediate completion without a sequence
        applyStimulus(3, 1, 1'b0, 3, "same_sel", hs);
        @(negedge clk);
        checkOutput("same_sel busy", busy, 0);
        @(negedge clk);
        checkOutput("same_sel busy later", busy, 0);
        waitDrain(5, "same_sel");

        // Out-of-range selects, including the first invalid index
        applyStimulus(7, 1, 1'b1, 3, "range7", hs);
        waitDrain(5, "range7");
        applyStimulus(6, 1, 1'b1, 3, "range6", hs);
        waitDrain(5, "range6");
        checkOutput("range cur_sel kept", cur_sel, 3);

        applyStimulus(0, 12, 1'b0, 0, "sw3to0", hs);
        waitDrain(40, "sw3to0");

        // Free-running phases, 0 -> 5; gate-on waits three cycles for phase 5 low
        free_run = 1'b1;
        repeat (10) @(negedge clk);
        while (cycle % 8 != 3) @(negedge clk);
        glitch_en = 1'b1;
        applyStimulus(5, 15, 1'b0, 5, "sw0to5_fr", hs);
        waitDrain(60, "sw0to5_fr");
        while (cycle < hs + 30) @(negedge clk);
        glitch_en = 1'b0;
        checkOutput("fr full pulses after switch", runs_seen, 2);
        checkOutput("fr cur_sel", cur_sel, 5);
        checkOutput("fr timeout_flag", timeout_flag, 0);

        // Old phase stuck high: gate-off forced on the 16th cycle
        free_run      = 1'b0;
        static_phases = 6'b100000;
        applyStimulus(2, 27, 1'b0, 2, "timeout", hs);
        while (cycle < hs + 15) @(negedge clk);
        checkOutput("tmo flag before force", timeout_flag, 0);
        checkOutput("tmo phase_out before force", phase_out, 1);
        @(negedge clk);
        checkOutput("tmo flag at force", timeout_flag, 1);
        checkOutput("tmo phase_out at force", phase_out, 0);
        waitDrain(40, "timeout");
        checkOutput("tmo cur_sel", cur_sel, 2);
        checkOutput("tmo flag sticky", timeout_flag, 1);

        // Reset during SETTLE_A with a request presented while busy
        static_phases = '0;
        applyStimulus(4, 0, 1'b0, 4, "rst_mid", hs);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = 3'd1;
        checkOutput("busy req_ready", req_ready, 0);
        checkOutput("busy busy", busy, 1);
        @(negedge clk);
        checkOutput("busy req_ready again", req_ready, 0);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst cur_sel", cur_sel, 0);
        checkOutput("midrst gate_en", dut.gate_en_q, 1);
        checkOutput("midrst busy", busy, 0);
        checkOutput("midrst req_ready", req_ready, 1);
        checkOutput("midrst timeout_flag", timeout_flag, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("post-rst cur_sel", cur_sel, 0);
        checkOutput("post-rst busy", busy, 0);
        checkOutput("post-rst gate_en", dut.gate_en_q, 1);
        waitDrain(5, "final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
